// File: rtl/dl_pkg.sv
// rtl/dl_pkg.sv - shared constants, state encoding and sel->depth table
package dl_pkg;

  localparam int MAX_DEPTH = 90;
  localparam int DEPTH_W   = 7;

  localparam logic [DEPTH_W-1:0] DEPTH_SEL0 = 7'd30;
  localparam logic [DEPTH_W-1:0] DEPTH_SEL1 = 7'd45;
  localparam logic [DEPTH_W-1:0] DEPTH_SEL2 = 7'd60;
  localparam logic [DEPTH_W-1:0] DEPTH_SEL3 = 7'd90;

  typedef enum logic [1:0] {
    ST_FILL  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  function automatic logic [DEPTH_W-1:0] sel_to_depth(input logic [1:0] sel);
    case (sel)
      2'd0:    return DEPTH_SEL0;
      2'd1:    return DEPTH_SEL1;
      2'd2:    return DEPTH_SEL2;
      default: return DEPTH_SEL3;
    endcase
  endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// rtl/delay_line_ctrl_if.sv - sample/select inputs and delayed-sample outputs
interface delay_line_ctrl_if #(parameter int WIDTH = 8);

  logic                       en;
  logic [WIDTH-1:0]           din;
  logic [1:0]                 sel;
  logic                       sel_load;
  logic [WIDTH-1:0]           dout;
  logic                       dout_valid;
  logic                       busy;
  logic [dl_pkg::DEPTH_W-1:0] depth;
  logic [1:0]                 state;

  modport master (
    output en, din, sel, sel_load,
    input  dout, dout_valid, busy, depth, state
  );

  modport slave (
    input  en, din, sel, sel_load,
    output dout, dout_valid, busy, depth, state
  );

endinterface

// File: rtl/dl_ring_mem.sv
// rtl/dl_ring_mem.sv - circular sample storage, one write port, async read
module dl_ring_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 90,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/delay_line_ctrl.sv
// rtl/delay_line_ctrl.sv - selectable-depth delay line: fill/run/flush FSM
module delay_line_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_DEPTH = dl_pkg::MAX_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  delay_line_ctrl_if.slave   bus
);

  import dl_pkg::*;

  state_e               state_q, state_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [DEPTH_W-1:0]   wptr_q, wptr_d;
  logic [DEPTH_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 mem_we;
  logic [DEPTH_W-1:0]   wptr_next;
  logic [DEPTH_W:0]     raddr_sum;
  logic [DEPTH_W-1:0]   raddr;
  logic [WIDTH-1:0]     rdata;

  // Read slot is depth entries behind wptr; at full depth it is the slot about to be overwritten.
  assign raddr_sum = {1'b0, wptr_q} + (DEPTH_W+1)'(MAX_DEPTH) - {1'b0, depth_q};
  assign raddr     = (raddr_sum >= (DEPTH_W+1)'(MAX_DEPTH))
                     ? DEPTH_W'(raddr_sum - (DEPTH_W+1)'(MAX_DEPTH))
                     : raddr_sum[DEPTH_W-1:0];
  assign wptr_next = (wptr_q == DEPTH_W'(MAX_DEPTH - 1)) ? '0 : wptr_q + 1'b1;

  dl_ring_mem #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (DEPTH_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    wptr_d     = wptr_q;
    fill_cnt_d = fill_cnt_q;
    dout_d     = dout_q;
    valid_d    = valid_q;
    mem_we     = 1'b0;
    if (bus.sel_load) begin
      depth_d    = sel_to_depth(bus.sel);
      state_d    = ST_FLUSH;
      fill_cnt_d = '0;
      dout_d     = '0;
      valid_d    = 1'b0;
    end else begin
      case (state_q)
        ST_FLUSH: state_d = ST_FILL;
        ST_FILL: begin
          if (bus.en) begin
            mem_we = ~rst;
            wptr_d = wptr_next;
            if (fill_cnt_q == depth_q) begin
              dout_d  = rdata;
              valid_d = 1'b1;
              state_d = ST_RUN;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.en) begin
            mem_we  = ~rst;
            wptr_d  = wptr_next;
            dout_d  = rdata;
            valid_d = 1'b1;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FILL;
      depth_q    <= DEPTH_SEL0;
      wptr_q     <= '0;
      fill_cnt_q <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      wptr_q     <= wptr_d;
      fill_cnt_q <= fill_cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.busy       = (state_q == ST_FLUSH);
  assign bus.depth      = depth_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb/tb_delay_line_ctrl.sv - randomized scoreboard bench for delay_line_ctrl
module tb_delay_line_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_line_ctrl_if #(.WIDTH(8)) bus ();

  delay_line_ctrl #(.WIDTH(8), .MAX_DEPTH(90)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic       v;
    logic [7:0] d;
    logic       b;
    logic [6:0] dep;
    logic [1:0] st;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] hist[$];
  int         dtab[4] = '{30, 45, 60, 90};
  int         m_depth = 30;
  bit         m_flush = 0;
  bit         m_valid = 0;
  logic [7:0] m_dout  = 8'd0;

  task automatic chk(input string nm, input int cy, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cy, act, exp);
    end
  endtask

  // Reference: only the last depth+1 accepted samples since reset/flush matter.
  task automatic step(input bit r, input bit e, input logic [7:0] d, input logic [1:0] s, input bit sl);
    exp_t x;
    rst = r; bus.en = e; bus.din = d; bus.sel = s; bus.sel_load = sl;
    if (r) begin
      hist.delete(); m_depth = 30; m_flush = 0; m_valid = 0; m_dout = 8'd0;
    end else if (sl) begin
      hist.delete(); m_depth = dtab[s]; m_flush = 1; m_valid = 0; m_dout = 8'd0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (e) begin
      hist.push_back(d);
      if (hist.size() > m_depth + 1) void'(hist.pop_front());
      if (hist.size() == m_depth + 1) begin
        m_valid = 1;
        m_dout  = hist[0];
      end
    end
    x.cyc = cyc + 1;
    x.v   = m_valid;
    x.d   = m_dout;
    x.b   = m_flush;
    x.dep = 7'(m_depth);
    x.st  = m_flush ? 2'b11 : (m_valid ? 2'b10 : 2'b01);
    sb.push_back(x);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("timing", cyc, 32'(cyc), 32'(e.cyc));
        chk("dout_valid", cyc, 32'(bus.dout_valid), 32'(e.v));
        chk("dout", cyc, 32'(bus.dout), 32'(e.d));
        chk("busy", cyc, 32'(bus.busy), 32'(e.b));
        chk("depth", cyc, 32'(bus.depth), 32'(e.dep));
        chk("state", cyc, 32'(bus.state), 32'(e.st));
      end
    end
  end

  initial begin : stim
    logic [7:0] v;
    rst = 1'b1; bus.en = 1'b0; bus.din = 8'd0; bus.sel = 2'd0; bus.sel_load = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 8'd0, 2'd0, 0);
    step(1, 1, 8'd7, 2'd3, 1);

    v = 8'd1;
    for (int i = 0; i < 45; i++) begin step(0, 1, v, 2'd0, 0); v++; end

    step(0, 0, 8'd0, 2'd3, 1);
    v = 8'd1;
    for (int i = 0; i < 200; i++) begin
      step(0, (i % 2) == 0, v, 2'($urandom_range(0, 3)), 0);
      if ((i % 2) == 0) v++;
    end

    step(0, 0, 8'd0, 2'd0, 1);
    for (int i = 0; i < 40; i++) step(0, 1, 8'($urandom), 2'd0, 0);
    step(0, 1, 8'hEE, 2'd1, 1);
    for (int i = 0; i < 50; i++) step(0, 1, 8'($urandom), 2'd2, 0);

    step(0, 0, 8'd0, 2'd0, 1);
    for (int i = 0; i < 35; i++) step(0, 1, 8'($urandom), 2'd0, 0);
    step(0, 0, 8'd0, 2'd0, 1);
    for (int i = 0; i < 35; i++) step(0, 1, 8'($urandom), 2'd0, 0);

    step(0, 0, 8'd0, 2'd2, 1);
    for (int i = 0; i < 65; i++) step(0, 1, 8'($urandom), 2'd0, 0);
    step(1, 1, 8'h55, 2'd3, 0);
    step(0, 0, 8'd0, 2'd0, 0);

    step(0, 1, 8'd9, 2'd2, 1);
    step(0, 1, 8'd9, 2'd1, 1);
    for (int i = 0; i < 50; i++) step(0, 1, 8'($urandom), 2'd0, 0);

    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           2'($urandom_range(0, 3)), $urandom_range(0, 39) == 0);
    end

    for (int i = 0; i < 3; i++) step(0, 0, 8'd0, 2'd0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_line_ctrl.md
DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, sample width in bits.
REQ-002 Parameter MAX_DEPTH, default 90, storage entries; largest selectable delay.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  sample strobe; each cycle with en=1 is one delay-line step.
REQ-006 din  input  WIDTH  sample written on a strobe.
REQ-007 sel  input  2  delay select: 0->30, 1->45, 2->60, 3->90 steps.
REQ-008 sel_load  input  1  one-cycle pulse applying sel.
REQ-009 dout  output  WIDTH  delayed sample, registered.
REQ-010 dout_valid  output  1  dout holds a real sample delayed by exactly the active depth.
REQ-011 busy  output  1  high in FLUSH; strobes in that cycle are dropped.
REQ-012 depth  output  7  active delay in steps (30/45/60/90).
REQ-013 state  output  2  FSM state: FILL=01, RUN=10, FLUSH=11.

Function
REQ-014 Storage SHALL be a MAX_DEPTH-entry circular buffer with write pointer wptr, 0..MAX_DEPTH-1, incrementing per accepted strobe and wrapping 89->0.
REQ-015 Read address SHALL be (wptr - depth + MAX_DEPTH) mod MAX_DEPTH, sampled before the same-edge write, so depth=90 reads the entry being overwritten.
REQ-016 Delay law: after accepted strobe k (k>=depth since last flush), dout SHALL equal din of strobe k-depth; latency is exactly depth strobes, independent of gaps in en.
REQ-017 FILL: fill_cnt counts accepted strobes from 0; dout=0, dout_valid=0; on the strobe where fill_cnt==depth, dout loads the read value, dout_valid=1, next state RUN; otherwise fill_cnt increments.
REQ-018 RUN: every strobe writes din, loads dout from read address; dout_valid=1; dout and dout_valid hold between strobes.
REQ-019 sel_load=1 in any state SHALL latch sel into depth, go to FLUSH next cycle, and drop that cycle's strobe (sel_load wins over en).
REQ-020 FLUSH SHALL last exactly one cycle: dout=0, dout_valid=0, busy=1, fill_cnt=0, wptr unchanged, any en ignored; next state FILL.
REQ-021 sel_load with sel equal to the active selection SHALL still flush.
REQ-022 sel_load during FLUSH SHALL re-latch sel and stay in FLUSH one further cycle.
REQ-023 Stale buffer contents SHALL never appear on dout with dout_valid=1.
REQ-024 fill_cnt SHALL be 7 bits and never exceed depth.

Reset
REQ-025 rst=1 SHALL, at the next edge, set state=FILL, depth=30, wptr=0, fill_cnt=0, dout=0, dout_valid=0, busy=0; overrides en and sel_load.
REQ-026 Buffer storage SHALL not be reset; REQ-023 covers stale data.
REQ-027 Reset asserted mid-RUN SHALL behave identically to power-up reset.

Structure
REQ-028 Shared package dl_pkg SHALL hold the sel->depth table constants (30/45/60/90), state encodings and MAX_DEPTH.
REQ-029 One sub-module dl_ring_mem (MAX_DEPTH x WIDTH, one write port, one asynchronous read port, no reset) SHALL hold storage; the FSM, pointers and counters live in delay_line_ctrl.

Verification
REQ-030 Reset, en=1 every cycle, din=1,2,3...: dout_valid rises after strobe 30 with dout=1; dout=n-30 thereafter.
REQ-031 sel=3 loaded, din ramp on every other cycle: first valid dout=first sample after 90 strobes; wptr wraps 89->0 with no glitch.
REQ-032 In RUN at depth 30, sel_load with sel=1 plus en same cycle: that din dropped, busy=1 one cycle, dout=0/valid=0, valid returns after 45 new strobes.
REQ-033 sel_load repeated with identical sel=0 mid-RUN: flush occurs, valid drops for 30 strobes, no pre-flush sample ever valid.
REQ-034 rst pulsed mid-RUN at depth 60: next cycle depth=30, state=FILL, dout=0, dout_valid=0.
REQ-035 Back-to-back sel_load 2 then 1 in consecutive cycles: two FLUSH cycles, final depth=45.
